carbon_uart_tx: RTL and testbench
=================================

// Module: carbon_uart_tx
// PURPOSE
//  Byte-stream to async-serial transmitter (8N1/8N2), far end of the MMIO console byte port (uart_tx_valid/uart_tx_byte).
//  Producer pulses one byte per cycle with no backpressure honoured, so an input FIFO absorbs bursts.
//  Drives a single idle-high serial line; used as the physical console for CarbonX86/CarbonZ system tops.
// PARAMETERS
//  CLKS_PER_BIT  16  clocks per serial bit; legal >= 2 (elaboration error otherwise)
//  FIFO_DEPTH    8   input FIFO entries; power of two, >= 2 (elaboration error otherwise)
//  STOP_BITS     1   stop bits per frame; legal 1 or 2
// PORTS
//  clk           in   1   single clock; all state on rising edge
//  rst           in   1   asynchronous, active-high reset
//  tx_valid      in   1   byte present this cycle (pulse or held)
//  tx_data       in   8   byte to send
//  tx_ready      out  1   FIFO not full (combinational from FIFO count)
//  txd           out  1   serial line, registered, idle 1
//  busy          out  1   FSM not IDLE or FIFO non-empty
//  fifo_level    out  $clog2(FIFO_DEPTH)+1  entries currently queued
//  overflow      out  1   sticky: a byte was offered while full and dropped
//  overflow_clr  in   1   clears overflow
// BEHAVIOUR
//  Reset (async assert, sync-free release): txd=1, busy=0, tx_ready=1, fifo_level=0, overflow=0, FSM=IDLE, FIFO emptied.
//  Reset mid-frame: frame abandoned, txd returns to 1 immediately, queued bytes discarded.
//  Push: tx_valid && tx_ready at edge -> byte enqueued. tx_valid && !tx_ready -> byte dropped, overflow<=1.
//   tx_ready depends on count only: a pop in the same cycle does not make room for a push while full.
//  overflow: set has priority over overflow_clr in the same cycle.
//  FSM states: IDLE, START, DATA, STOP.
//   IDLE: if FIFO non-empty -> pop head into shift reg, txd<=0, baud_cnt<=CLKS_PER_BIT-1, bit_idx<=0, -> START.
//   START: hold txd=0 for CLKS_PER_BIT cycles; at baud_cnt==0 -> txd<=shift[0], -> DATA.
//   DATA: each bit CLKS_PER_BIT cycles, LSB first; after bit 7 -> txd<=1, stop_cnt<=STOP_BITS-1, -> STOP.
//   STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles; at end, FIFO non-empty -> pop, txd<=0, -> START (no idle gap);
//    else -> IDLE.
//  baud_cnt: down-counter, reload CLKS_PER_BIT-1 on every bit boundary; width $clog2(CLKS_PER_BIT).
//  Latency: byte accepted at edge E0 into empty FIFO with FSM IDLE -> pop at E1, txd low from E1.
//  Frame length: (1+8+STOP_BITS)*CLKS_PER_BIT cycles exactly; back-to-back frames contiguous.
//  fifo_level updates at the edge of the push/pop; simultaneous push+pop (not full) leaves level unchanged.
//  busy falls at the edge the FSM enters IDLE with FIFO empty.
// STRUCTURE
//  carbon_uart_pkg: uart_tx_state_e {IDLE,START,DATA,STOP}, UART_IDLE_LEVEL=1'b1, UART_DATA_BITS=8.
//  Sub-module carbon_sync_fifo (DEPTH, WIDTH=8; push/pop/full/empty/level); FSM, baud counter, shifter in this module.
// TESTING
//  1 Reset: hold rst -> txd=1, busy=0, tx_ready=1, fifo_level=0, overflow=0; assert rst async mid-cycle, outputs follow.
//  2 CLKS_PER_BIT=4: push 0x58 -> txd 0 from E1 for 4 clk, then 0,0,0,1,1,0,1,0 x4 clk each, 1 x4; busy low at E1+40.
//  3 Push "X86!" (0x58,0x38,0x36,0x21) on 4 consecutive cycles -> 4 contiguous frames, 160 cycles, no idle between.
//  4 DEPTH=8: push 12 bytes consecutive cycles -> 9 sent (1 popped at E1 + 8 queued), 3 dropped, overflow=1;
//    overflow_clr with concurrent dropped push -> overflow stays 1; clr alone -> 0.
//  5 Assert rst during DATA bit 3 with 3 bytes queued -> txd=1 at once, fifo_level=0; after release, txd stays 1.
//  6 STOP_BITS=2, CLKS_PER_BIT=4: two back-to-back bytes -> each frame 44 cycles, stop held high 8 cycles.

Source files
------------

// File: rtl/carbon_uart_pkg.sv
// Shared types and constants for the Carbon console UART transmitter.
package carbon_uart_pkg;

   // Transmit FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_e;

   // Serial line level between frames and during stop bits
   localparam logic UART_IDLE_LEVEL = 1'b1;

   // Data bits per frame, always sent LSB first
   localparam int UART_DATA_BITS = 8;

   // Number of bits needed to hold an entry count from 0 to depth
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/carbon_sync_fifo.sv
// Single-clock FIFO with an occupancy count. Full/empty depend only on the
// stored count, so a pop in the same cycle never makes room for a push.
module carbon_sync_fifo
   import carbon_uart_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [WIDTH-1:0]              din,
   input  logic                          pop,
   output logic [WIDTH-1:0]              dout,
   output logic                          full,
   output logic                          empty,
   output logic [level_width(DEPTH)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_width(DEPTH);

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("carbon_sync_fifo: DEPTH must be a power of two and >= 2");
      end
   endgenerate

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    count_q;
   logic [LW-1:0]    count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == LW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];
   assign level   = count_q;

   // Next occupancy: a simultaneous push and pop leaves the count unchanged
   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // Pointers and count; pointer wrap is free because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/carbon_uart_tx.sv
// Console byte stream to 8N1/8N2 serial transmitter. An input FIFO absorbs
// producer bursts; the FSM serialises one frame at a time and chains queued
// bytes with no idle gap between frames.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | line high, waiting for a queued byte
//  START | start bit (low) for CLKS_PER_BIT cycles
//  DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
//  STOP  | line high for STOP_BITS bit times, then next byte or IDLE
module carbon_uart_tx
   import carbon_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               tx_valid,
   input  logic [7:0]                         tx_data,
   output logic                               tx_ready,
   output logic                               txd,
   output logic                               busy,
   output logic [level_width(FIFO_DEPTH)-1:0] fifo_level,
   output logic                               overflow,
   input  logic                               overflow_clr
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int LW = level_width(FIFO_DEPTH);

   localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_BIT    = 3'(UART_DATA_BITS - 1);
   localparam logic          STOP_RELOAD = 1'(STOP_BITS - 1);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_cpb
         $error("carbon_uart_tx: CLKS_PER_BIT must be >= 2");
      end
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
         $error("carbon_uart_tx: STOP_BITS must be 1 or 2");
      end
   endgenerate

   uart_tx_state_e state_q;
   logic           txd_q;
   logic [BW-1:0]  baud_q;
   logic [BW-1:0]  baud_d;
   logic [2:0]     bit_idx_q;
   logic           stop_cnt_q;
   logic [7:0]     shift_q;
   logic           overflow_q;
   logic           overflow_d;

   logic           fifo_full;
   logic           fifo_empty;
   logic [7:0]     fifo_dout;
   logic [LW-1:0]  fifo_count;
   logic           fifo_pop;
   logic           baud_zero;
   logic           frame_done;
   logic           drop;

   carbon_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_valid),
      .din   (tx_data),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_count)
   );

   assign tx_ready   = !fifo_full;
   assign fifo_level = fifo_count;
   assign txd        = txd_q;
   assign overflow   = overflow_q;
   assign busy       = (state_q != IDLE) || !fifo_empty;

   assign baud_zero  = (baud_q == '0);
   assign baud_d     = baud_q - 1'b1;
   assign frame_done = (state_q == STOP) && baud_zero && (stop_cnt_q == 1'b0);
   assign drop       = tx_valid && fifo_full;

   // Head of FIFO is consumed when idle or at the last cycle of a stop bit
   always_comb begin
      fifo_pop = 1'b0;
      if (!fifo_empty && ((state_q == IDLE) || frame_done)) begin
         fifo_pop = 1'b1;
      end
   end

   // Sticky overflow: a dropped byte wins over a clear in the same cycle
   always_comb begin
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (overflow_clr) begin
         overflow_d = 1'b0;
      end
   end

   // Overflow flag register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   // Transmit FSM with baud down-counter, bit index and shifter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         txd_q      <= UART_IDLE_LEVEL;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         stop_cnt_q <= 1'b0;
         shift_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               txd_q <= UART_IDLE_LEVEL;
               if (fifo_pop) begin
                  shift_q   <= fifo_dout;
                  txd_q     <= 1'b0;
                  baud_q    <= BAUD_RELOAD;
                  bit_idx_q <= '0;
                  state_q   <= START;
               end
            end

            START: begin
               if (baud_zero) begin
                  txd_q   <= shift_q[0];
                  baud_q  <= BAUD_RELOAD;
                  state_q <= DATA;
               end else begin
                  baud_q <= baud_d;
               end
            end

            DATA: begin
               if (baud_zero) begin
                  baud_q <= BAUD_RELOAD;
                  if (bit_idx_q == LAST_BIT) begin
                     txd_q      <= UART_IDLE_LEVEL;
                     stop_cnt_q <= STOP_RELOAD;
                     state_q    <= STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                     txd_q     <= shift_q[1];
                     shift_q   <= shift_q >> 1;
                  end
               end else begin
                  baud_q <= baud_d;
               end
            end

            STOP: begin
               if (baud_zero) begin
                  if (stop_cnt_q != 1'b0) begin
                     stop_cnt_q <= stop_cnt_q - 1'b1;
                     baud_q     <= BAUD_RELOAD;
                  end else if (fifo_pop) begin
                     // Chain straight into the next start bit
                     shift_q   <= fifo_dout;
                     txd_q     <= 1'b0;
                     baud_q    <= BAUD_RELOAD;
                     bit_idx_q <= '0;
                     state_q   <= START;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  baud_q <= baud_d;
               end
            end

            default: begin
               state_q <= IDLE;
               txd_q   <= UART_IDLE_LEVEL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_carbon_uart_tx.sv
// Bench for carbon_uart_tx: two instances (1 and 2 stop bits, 4 clocks/bit).
// A serial receiver model decodes frames and checks them against a queue of
// expected bytes filled by the stimulus.
module tb_carbon_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic          v1 = 1'b0, clr1 = 1'b0;
   logic [7:0]    d1 = '0;
   logic          ready1, txd1, busy1, ovf1;
   logic [LW-1:0] lvl1;

   logic          v2 = 1'b0, clr2 = 1'b0;
   logic [7:0]    d2 = '0;
   logic          ready2, txd2, busy2, ovf2;
   logic [LW-1:0] lvl2;

   carbon_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst(rst), .tx_valid(v1), .tx_data(d1), .tx_ready(ready1),
      .txd(txd1), .busy(busy1), .fifo_level(lvl1), .overflow(ovf1),
      .overflow_clr(clr1)
   );

   carbon_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .tx_valid(v2), .tx_data(d2), .tx_ready(ready2),
      .txd(txd2), .busy(busy2), .fifo_level(lvl2), .overflow(ovf2),
      .overflow_clr(clr2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard state
   logic [7:0] exp_q[$];
   int         starts[$];
   int         frames_rx = 0;
   bit         mon_en = 1'b0;
   bit         sel = 1'b0;
   wire        mon_txd = sel ? txd2 : txd1;

   // Receiver model: mid-bit sampling, pops and compares on each frame
   initial begin
      logic       prev;
      logic [7:0] rx;
      int         s;
      int         nstop;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (mon_en && prev === 1'b1 && mon_txd === 1'b0) begin
            s     = cyc;
            nstop = sel ? 2 : 1;
            repeat (CPB / 2) @(negedge clk);
            check("start_bit", 32'(mon_txd), 32'd0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               rx[i] = mon_txd;
            end
            for (int j = 0; j < nstop; j++) begin
               repeat (CPB) @(negedge clk);
               check("stop_bit", 32'(mon_txd), 32'd1);
            end
            starts.push_back(s);
            frames_rx++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL rx_byte: got %02h expected no frame", rx);
            end else begin
               check("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
            end
         end
         prev = mon_txd;
      end
   end

   task automatic push(input bit which, input logic [7:0] b);
      @(negedge clk);
      if (which) begin v2 = 1'b1; d2 = b; end
      else       begin v1 = 1'b1; d1 = b; end
   endtask

   task automatic idle_in(input bit which);
      @(negedge clk);
      if (which) v2 = 1'b0;
      else       v1 = 1'b0;
   endtask

   task automatic wait_idle(input bit which, input int budget, output int t_low);
      bit done;
      done  = 1'b0;
      t_low = -1;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (!(which ? busy2 : busy1)) begin
            done  = 1'b1;
            t_low = cyc;
         end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_idle: busy still high after %0d cycles", budget);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         t_low;
      int         errs;
      int         f0;
      logic [9:0] frame;

      // 1: reset state, then asynchronous assert mid-frame
      repeat (3) @(negedge clk);
      check("rst_txd", 32'(txd1), 32'd1);
      check("rst_busy", 32'(busy1), 32'd0);
      check("rst_ready", 32'(ready1), 32'd1);
      check("rst_level", 32'(lvl1), 32'd0);
      check("rst_ovf", 32'(ovf1), 32'd0);
      check("rst_txd2", 32'(txd2), 32'd1);
      @(negedge clk) rst = 1'b0;
      push(1'b0, 8'h00);
      idle_in(1'b0);
      @(negedge clk);
      check("t1_start_low", 32'(txd1), 32'd0);
      #2 rst = 1'b1;
      #1;
      check("t1_async_txd", 32'(txd1), 32'd1);
      check("t1_async_busy", 32'(busy1), 32'd0);
      check("t1_async_level", 32'(lvl1), 32'd0);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);

      // 2: single byte 0x58, exact waveform and busy fall at E1+40
      mon_en = 1'b1;
      exp_q.push_back(8'h58);
      push(1'b0, 8'h58);
      idle_in(1'b0);
      check("t2_level", 32'(lvl1), 32'd1);
      check("t2_txd_pre", 32'(txd1), 32'd1);
      check("t2_busy_pre", 32'(busy1), 32'd1);
      frame = {1'b1, 8'h58, 1'b0};
      errs  = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (txd1 !== frame[k / CPB]) errs++;
      end
      check("t2_wave_errs", 32'(errs), 32'd0);
      check("t2_busy_last", 32'(busy1), 32'd1);
      @(negedge clk);
      check("t2_busy_end", 32'(busy1), 32'd0);
      check("t2_txd_end", 32'(txd1), 32'd1);
      repeat (4) @(negedge clk);

      // 3: "X86!" back-to-back, four contiguous frames of 40 cycles
      starts.delete();
      exp_q.push_back(8'h58); exp_q.push_back(8'h38);
      exp_q.push_back(8'h36); exp_q.push_back(8'h21);
      push(1'b0, 8'h58); push(1'b0, 8'h38); push(1'b0, 8'h36); push(1'b0, 8'h21);
      idle_in(1'b0);
      wait_idle(1'b0, 400, t_low);
      repeat (4) @(negedge clk);
      check("t3_frames", 32'(starts.size()), 32'd4);
      if (starts.size() == 4) begin
         for (int i = 0; i < 3; i++)
            check("t3_gap", 32'(starts[i+1] - starts[i]), 32'd40);
         check("t3_total", 32'(t_low - starts[0]), 32'd160);
      end

      // 4: 12-byte burst into depth 8: 9 sent, 3 dropped, sticky overflow
      f0 = frames_rx;
      for (int i = 0; i < 9; i++) exp_q.push_back(8'h30 + 8'(i));
      for (int i = 0; i < 12; i++) push(1'b0, 8'h30 + 8'(i));
      idle_in(1'b0);
      check("t4_ovf_set", 32'(ovf1), 32'd1);
      check("t4_level_full", 32'(lvl1), 32'd8);
      check("t4_ready_low", 32'(ready1), 32'd0);
      @(negedge clk);
      clr1 = 1'b1; v1 = 1'b1; d1 = 8'hEE;
      @(negedge clk);
      clr1 = 1'b0; v1 = 1'b0;
      check("t4_set_beats_clr", 32'(ovf1), 32'd1);
      check("t4_level_kept", 32'(lvl1), 32'd8);
      @(negedge clk) clr1 = 1'b1;
      @(negedge clk) clr1 = 1'b0;
      check("t4_clr", 32'(ovf1), 32'd0);
      wait_idle(1'b0, 9 * 40 + 60, t_low);
      repeat (4) @(negedge clk);
      check("t4_frames", 32'(frames_rx - f0), 32'd9);
      check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

      // 5: reset during data bit 3 with three bytes queued
      mon_en = 1'b0;
      for (int i = 0; i < 4; i++) push(1'b0, 8'h00);
      idle_in(1'b0);
      repeat (15) @(negedge clk);
      check("t5_bit3_low", 32'(txd1), 32'd0);
      check("t5_level3", 32'(lvl1), 32'd3);
      #2 rst = 1'b1;
      #1;
      check("t5_txd_high", 32'(txd1), 32'd1);
      check("t5_level0", 32'(lvl1), 32'd0);
      check("t5_ready", 32'(ready1), 32'd1);
      @(negedge clk) rst = 1'b0;
      errs = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (txd1 !== 1'b1 || busy1 !== 1'b0) errs++;
      end
      check("t5_quiet_errs", 32'(errs), 32'd0);

      // 6: two stop bits, two back-to-back frames of 44 cycles
      sel    = 1'b1;
      mon_en = 1'b1;
      starts.delete();
      exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
      push(1'b1, 8'hA5); push(1'b1, 8'h3C);
      idle_in(1'b1);
      check("t6_start", 32'(txd2), 32'd0);
      errs = 0;
      for (int k = 1; k <= 44; k++) begin
         @(negedge clk);
         if (k >= 36 && k <= 43 && txd2 !== 1'b1) errs++;
         if (k == 44 && txd2 !== 1'b0) errs++;
      end
      check("t6_stop_errs", 32'(errs), 32'd0);
      wait_idle(1'b1, 200, t_low);
      repeat (4) @(negedge clk);
      check("t6_frames", 32'(starts.size()), 32'd2);
      if (starts.size() == 2) begin
         check("t6_gap", 32'(starts[1] - starts[0]), 32'd44);
         check("t6_total", 32'(t_low - starts[0]), 32'd88);
      end
      check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
